// File: rtl/video_pkg.sv
// Shared types and defaults for the video RAM arbiter and its posted write buffer.
package video_pkg;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_STARVE_LIMIT = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        ACK     = 3'd4
    } arb_state_t;

    function automatic logic is_wait_state(input arb_state_t s);
        return (s == WR_WAIT) || (s == RD_WAIT);
    endfunction

endpackage

// File: rtl/video_ram_wbuf.sv
// One-entry posted write buffer. An entry is not offered for draining in the cycle
// right after it is loaded, so a write reaches the RAM no earlier than the ack cycle + 1.
module video_ram_wbuf
    import video_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              drain,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic              valid,
    output logic              drain_ok,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              hit
);

    logic              valid_q, valid_d;
    logic              fresh_q, fresh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next-state of the buffer entry: load has precedence over drain.
    always_comb begin
        valid_d = valid_q;
        fresh_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            fresh_d = 1'b1;
            addr_d  = ld_addr;
            data_d  = ld_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Buffer entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            fresh_q <= fresh_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign drain_ok = valid_q & ~fresh_q;
    assign addr     = addr_q;
    assign data     = data_q;
    assign hit      = valid_q && (addr_q == cmp_addr);

endmodule

// File: rtl/video_ram_arbiter.sv
// Single-port video RAM arbiter: video reads always win the port, CPU ops use free
// cycles through a req/ack FSM backed by a one-entry posted write buffer.
module video_ram_arbiter
    import video_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_starved,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              starved_q, starved_d;
    logic              vid_valid_q, vid_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              wb_load_s, wb_valid_s, wb_drain_ok_s, wb_hit_s;
    logic              drain_s, rd_issue_s;
    logic [ADDR_W-1:0] wb_addr_s;
    logic [DATA_W-1:0] wb_data_s;

    video_ram_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .load     (wb_load_s),
        .ld_addr  (cpu_addr),
        .ld_data  (cpu_din),
        .drain    (drain_s),
        .cmp_addr (cpu_addr),
        .valid    (wb_valid_s),
        .drain_ok (wb_drain_ok_s),
        .addr     (wb_addr_s),
        .data     (wb_data_s),
        .hit      (wb_hit_s)
    );

    // Free-slot use: a pending drain beats a CPU read issue; video beats both.
    assign drain_s    = ~vid_req & wb_drain_ok_s;
    assign rd_issue_s = ~vid_req & ~wb_valid_s & (state_q == RD_WAIT);

    // RAM port mux.
    always_comb begin
        ram_din = wb_data_s;
        if (vid_req) begin
            ram_en   = 1'b1;
            ram_we   = 1'b0;
            ram_addr = vid_addr;
        end else if (drain_s) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wb_addr_s;
        end else if (rd_issue_s) begin
            ram_en   = 1'b1;
            ram_we   = 1'b0;
            ram_addr = cpu_addr;
        end else begin
            ram_en   = 1'b0;
            ram_we   = 1'b0;
            ram_addr = cpu_addr;
        end
    end

    // CPU FSM next state, read data capture and buffer load.
    always_comb begin
        state_d    = state_q;
        cpu_dout_d = cpu_dout_q;
        wb_load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && cpu_we && !wb_valid_s) begin
                    wb_load_s = 1'b1;
                    state_d   = ACK;
                end else if (cpu_req && cpu_we) begin
                    state_d = WR_WAIT;
                end else if (cpu_req && wb_hit_s) begin
                    cpu_dout_d = wb_data_s;
                    state_d    = ACK;
                end else if (cpu_req) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                if (!wb_valid_s) begin
                    wb_load_s = 1'b1;
                    state_d   = ACK;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (rd_issue_s) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_DATA: begin
                cpu_dout_d = ram_dout;
                state_d    = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ack pulse, stall counter and sticky starvation flag.
    always_comb begin
        cpu_ack_d   = (state_d == ACK);
        vid_valid_d = vid_req;
        if (!is_wait_state(state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == LIMIT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == LIMIT_C) begin
            starved_d = 1'b1;
        end else begin
            starved_d = starved_q;
        end
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            starved_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            starved_q   <= starved_d;
            vid_valid_q <= vid_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_starved = starved_q;
    assign vid_valid   = vid_valid_q;
    assign vid_dout    = ram_dout;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Scoreboard bench for video_ram_arbiter: a behavioural RAM, a shadow memory of the
// CPU-visible contents, and expectation queues popped by a negedge monitor.
module tb_video_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_ack, cpu_starved;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic [7:0]  vid_dout;
    logic        vid_valid;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vid_mode = 0;
    int vid_last_hi = -1;
    int last_we_cyc = -1;
    logic prev_vid_req = 1'b0;

    logic [7:0]  mem    [4096];
    logic [7:0]  shadow [4096];
    logic [7:0]  vid_q[$];
    logic [19:0] wr_q[$];
    bit          ack_rd_q[$];
    logic [7:0]  ack_data_q[$];

    video_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_starved(cpu_starved),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous single-port RAM.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Video traffic generator; every strobe pushes the preloaded pattern value.
    initial begin
        vid_req  = 1'b0;
        vid_addr = 12'h000;
        forever begin
            @(posedge clk);
            #2;
            case (vid_mode)
                0:       vid_req = 1'b0;
                1:       vid_req = 1'b1;
                default: vid_req = 1'($urandom_range(0, 1));
            endcase
            vid_addr = 12'($urandom_range(0, 255));
            if (vid_req) begin
                vid_q.push_back(vid_addr[7:0]);
                vid_last_hi = cyc;
            end
        end
    end

    // Monitor: video data, slot ownership, RAM write order, CPU acks.
    always @(negedge clk) begin
        logic [7:0]  ev;
        logic [19:0] ew;
        chk("vid_valid", {31'd0, vid_valid}, {31'd0, prev_vid_req});
        if (vid_valid) begin
            if (vid_q.size() == 0) chk("vid_extra", 32'd1, 32'd0);
            else begin
                ev = vid_q.pop_front();
                chk("vid_dout", {24'd0, vid_dout}, {24'd0, ev});
            end
        end
        if (vid_req)
            chk("vid_slot", {18'd0, ram_en, ram_we, ram_addr}, {18'd0, 1'b1, 1'b0, vid_addr});
        if (ram_en && ram_we) begin
            last_we_cyc = cyc;
            if (wr_q.size() == 0) chk("ram_we_unexpected", {12'd0, ram_addr, ram_din}, 32'd0);
            else begin
                ew = wr_q.pop_front();
                chk("ram_write", {12'd0, ram_addr, ram_din}, {12'd0, ew});
            end
        end
        if (cpu_ack) begin
            if (ack_rd_q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
            else begin
                ev = ack_data_q.pop_front();
                if (ack_rd_q.pop_front()) chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, ev});
            end
        end
        prev_vid_req = vid_req;
    end

    task automatic cpu_op(input logic we, input logic [11:0] addr, input logic [7:0] din,
                          output int lat, output int ack_cyc);
        int n = 0;
        bit done = 1'b0;
        lat = -1;
        ack_cyc = -1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        if (we) begin
            shadow[addr] = din;
            wr_q.push_back({addr, din});
            ack_rd_q.push_back(1'b0);
            ack_data_q.push_back(8'h00);
        end else begin
            ack_rd_q.push_back(1'b1);
            ack_data_q.push_back(shadow[addr]);
        end
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (cpu_ack) begin
                done = 1'b1;
                lat = n;
                ack_cyc = cyc;
            end
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("cpu_ack_in_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_dout"}, {24'd0, cpu_dout}, 32'd0);
        chk({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 32'd0);
        chk({tag, "_starved"}, {31'd0, cpu_starved}, 32'd0);
        chk({tag, "_vid_valid"}, {31'd0, vid_valid}, 32'd0);
        chk({tag, "_ram_en_we"}, {30'd0, ram_en, ram_we}, 32'd0);
    endtask

    initial begin
        int lat, ac, t;
        logic [7:0] old;
        for (int a = 0; a < 4096; a++) begin
            mem[a]    = 8'(a);
            shadow[a] = 8'(a);
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_din = 8'h00;
        step(3);
        check_reset_outputs("reset0");
        reset = 1'b0;
        step(2);

        // Video only.
        vid_mode = 1;
        step(20);
        vid_mode = 0;
        step(3);

        // Idle write then RAM read.
        cpu_op(1'b1, 12'h3A2, 8'h55, lat, ac);
        chk("idle_write_latency", lat, 32'd1);
        t = ac - 1;
        step(2);
        chk("idle_write_ram_we_cycle", last_we_cyc, t + 2);
        cpu_op(1'b0, 12'h3A2, 8'h00, lat, ac);
        chk("ram_read_latency", lat, 32'd3);

        // Forwarded read while video owns the port.
        vid_mode = 1;
        step(1);
        cpu_op(1'b1, 12'h100, 8'hAA, lat, ac);
        chk("busy_write_latency", lat, 32'd1);
        step(3);
        cpu_op(1'b0, 12'h100, 8'h00, lat, ac);
        chk("forward_read_latency", lat, 32'd1);
        step(5);
        vid_mode = 0;
        step(4);

        // Second write waits for the first to drain.
        vid_mode = 1;
        step(1);
        cpu_op(1'b1, 12'h400, 8'h12, lat, ac);
        chk("first_write_latency", lat, 32'd1);
        fork
            cpu_op(1'b1, 12'h401, 8'h34, lat, ac);
            begin
                step(10);
                vid_mode = 0;
            end
        join
        chk("second_write_ack_cycle", ac, vid_last_hi + 3);
        step(4);

        // Starvation under 70 cycles of continuous video.
        vid_mode = 1;
        step(1);
        fork
            cpu_op(1'b0, 12'h200, 8'h00, lat, ac);
            begin
                step(63);
                chk("not_starved_at_63", {31'd0, cpu_starved}, 32'd0);
                step(2);
                chk("starved_at_65", {31'd0, cpu_starved}, 32'd1);
                step(5);
                vid_mode = 0;
            end
        join
        chk("starved_read_ack_cycle", ac, vid_last_hi + 3);
        chk("starved_sticky", {31'd0, cpu_starved}, 32'd1);
        step(3);

        // Reset with a freshly buffered write.
        cpu_op(1'b0, 12'h3A2, 8'h00, lat, ac);
        old = shadow[12'h2F0];
        cpu_op(1'b1, 12'h2F0, 8'h11, lat, ac);
        reset = 1'b1;
        step(2);
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        if (wr_q.size() > 0) void'(wr_q.pop_back());
        shadow[12'h2F0] = old;
        step(5);
        cpu_op(1'b0, 12'h2F0, 8'h00, lat, ac);
        chk("post_reset_read_latency", lat, 32'd3);

        // Random mix with random video traffic.
        vid_mode = 2;
        for (int i = 0; i < 150; i++) begin
            cpu_op(1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 15)),
                   8'($urandom), lat, ac);
            step($urandom_range(0, 2));
        end
        vid_mode = 0;
        step(10);

        chk("vid_queue_empty", vid_q.size(), 32'd0);
        chk("write_queue_empty", wr_q.size(), 32'd0);
        chk("ack_queue_empty", ack_rd_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
